sync_pulse_rx_multi: RTL and testbench

Multi-channel receiver that brings asynchronous event inputs into the `clk` domain. Each channel has a parametrised synchronizer and a runtime-selectable edge-detect mode. Detected events are queued in a saturating per-channel pending counter and replayed as single-cycle pulses, spaced at least `GAP` idle cycles apart. It extends the two-flop pulse synchronizer with several channels, rise/fall/both/level modes, event queueing and sticky overflow reporting, so slow downstream logic never loses or merges back-to-back events.

---
 rtl/sync_pulse_pkg.sv | 24 ++
 rtl/sync_pulse_chan.sv | 119 +++++++++++
 rtl/sync_pulse_rx_multi.sv | 40 ++++
 tb/tb_sync_pulse_rx_multi.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pulse_pkg.sv
// Shared definitions for the multi-channel pulse receiver: edge-mode encodings
// and the gap-counter width helper.
package sync_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_RISE  = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_BOTH  = 2'b10,
        MODE_LEVEL = 2'b11
    } mode_e;

    // Gap counter must hold GAP itself; a zero gap still needs one bit.
    function automatic int gap_w(input int gap);
        int w;
        w = $clog2(gap + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_pulse_chan.sv
// One receiver channel: synchronizer, edge detect, saturating pending queue,
// inter-pulse gap counter and sticky overflow flag.
module sync_pulse_chan
    import sync_pulse_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3,
    parameter int GAP         = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       async_in,
    input  logic [1:0] mode,
    input  logic       ovf_clr,
    output logic       pulse_out,
    output logic       signal_out,
    output logic       busy,
    output logic       ovf
);

    localparam int               GAP_W    = gap_w(GAP);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic [CNT_W-1:0]       pend_r;
    logic [GAP_W-1:0]       gap_r;
    logic                   pulse_r;
    logic                   busy_r;
    logic                   ovf_r;

    logic                   last_s;
    logic                   event_s;
    logic                   issue_s;
    logic                   drop_s;
    logic [CNT_W-1:0]       pend_next_s;
    logic [GAP_W-1:0]       gap_next_s;
    logic                   ovf_next_s;

    assign last_s = sync_r[SYNC_STAGES-1];

    // Edge classification of the synchronized level against its one-cycle history.
    always_comb begin
        event_s = 1'b0;
        case (mode_e'(mode))
            MODE_RISE:  event_s = last_s & ~hist_r;
            MODE_FALL:  event_s = ~last_s & hist_r;
            MODE_BOTH:  event_s = last_s ^ hist_r;
            MODE_LEVEL: event_s = 1'b0;
            default:    event_s = 1'b0;
        endcase
    end

    // Queue, gap and overflow next-state; a simultaneous issue absorbs an event at max.
    always_comb begin
        issue_s = (pend_r != PEND_ZERO) && (gap_r == GAP_ZERO);
        drop_s  = event_s && !issue_s && (pend_r == PEND_MAX);

        if (event_s && !issue_s) begin
            if (pend_r != PEND_MAX) begin
                pend_next_s = pend_r + PEND_ONE;
            end else begin
                pend_next_s = pend_r;
            end
        end else if (issue_s && !event_s) begin
            pend_next_s = pend_r - PEND_ONE;
        end else begin
            pend_next_s = pend_r;
        end

        if (issue_s) begin
            gap_next_s = GAP_LOAD;
        end else if (gap_r != GAP_ZERO) begin
            gap_next_s = gap_r - GAP_ONE;
        end else begin
            gap_next_s = gap_r;
        end

        if (drop_s) begin
            ovf_next_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Channel state registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            hist_r  <= 1'b0;
            pend_r  <= PEND_ZERO;
            gap_r   <= GAP_ZERO;
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], async_in};
            hist_r  <= last_s;
            pend_r  <= pend_next_s;
            gap_r   <= gap_next_s;
            pulse_r <= issue_s;
            busy_r  <= (pend_next_s != PEND_ZERO) || (gap_next_s != GAP_ZERO);
            ovf_r   <= ovf_next_s;
        end
    end

    assign pulse_out  = pulse_r;
    assign signal_out = last_s;
    assign busy       = busy_r;
    assign ovf        = ovf_r;

endmodule

// File: rtl/sync_pulse_rx_multi.sv
// Multi-channel asynchronous event receiver: CH independent copies of
// sync_pulse_chan with no cross-channel interaction.
module sync_pulse_rx_multi
    import sync_pulse_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3,
    parameter int GAP         = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   async_in,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   ovf_clr,
    output logic [CH-1:0]   pulse_out,
    output logic [CH-1:0]   signal_out,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   ovf
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        sync_pulse_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .GAP         (GAP)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .async_in   (async_in[i]),
            .mode       (mode[2*i +: 2]),
            .ovf_clr    (ovf_clr[i]),
            .pulse_out  (pulse_out[i]),
            .signal_out (signal_out[i]),
            .busy       (busy[i]),
            .ovf        (ovf[i])
        );
    end

endmodule

// File: tb/tb_sync_pulse_rx_multi.sv
// Scoreboard bench for sync_pulse_rx_multi: a timestamp-based reference model
// predicts every output cycle, a monitor compares, directed checks cover the test plan.
module tb_sync_pulse_rx_multi;

    localparam int CH   = 4;
    localparam int S    = 2;
    localparam int CW   = 3;
    localparam int GAP  = 3;
    localparam int MAXP = (1 << CW) - 1;

    logic            clk;
    logic            rst_n;
    logic [CH-1:0]   async_in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   ovf_clr;
    logic [CH-1:0]   pulse_out;
    logic [CH-1:0]   signal_out;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CH-1:0] p;
        logic [CH-1:0] s;
        logic [CH-1:0] b;
        logic [CH-1:0] o;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: recent input samples, queue depth, time of last issue.
    logic [CH-1:0] in_hist[$];
    int pend[CH];
    int last_iss[CH];
    bit ovf_m[CH];
    int cyc = 0;

    // DUT observation counters kept by the monitor.
    int pc[CH];
    int bc[CH];
    int oc[CH];

    sync_pulse_rx_multi #(
        .CH          (CH),
        .SYNC_STAGES (S),
        .CNT_W       (CW),
        .GAP         (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (async_in),
        .mode       (mode),
        .ovf_clr    (ovf_clr),
        .pulse_out  (pulse_out),
        .signal_out (signal_out),
        .busy       (busy),
        .ovf        (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        in_hist = {};
        repeat (S + 1) in_hist.push_back('0);
        for (int c = 0; c < CH; c++) begin
            pend[c]     = 0;
            last_iss[c] = -1000;
            ovf_m[c]    = 1'b0;
        end
    endtask

    // One clock edge of the behavioural model, using inputs as sampled at that edge.
    task automatic model_step();
        exp_t e;
        bit   cur, prv, ev, iss, drop;
        logic [1:0] md;
        cyc++;
        e.p = '0; e.s = '0; e.b = '0; e.o = '0;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(e);
            return;
        end
        for (int c = 0; c < CH; c++) begin
            cur = in_hist[S-1][c];
            prv = in_hist[S][c];
            md  = mode[2*c +: 2];
            ev  = (md == 2'd0 && cur && !prv) || (md == 2'd1 && !cur && prv) ||
                  (md == 2'd2 && cur != prv);
            iss = (pend[c] > 0) && (cyc >= last_iss[c] + GAP + 1);
            if (iss) last_iss[c] = cyc;
            drop = ev && !iss && (pend[c] == MAXP);
            if (ev && !iss && !drop) pend[c]++;
            else if (iss && !ev) pend[c]--;
            if (drop) ovf_m[c] = 1'b1;
            else if (ovf_clr[c]) ovf_m[c] = 1'b0;
            e.p[c] = iss;
            e.b[c] = (pend[c] > 0) || (last_iss[c] + GAP - cyc > 0);
            e.o[c] = ovf_m[c];
        end
        in_hist.push_front(async_in);
        void'(in_hist.pop_back());
        e.s = in_hist[S-1];
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_out", 32'(pulse_out), 32'(e.p));
                chk("signal_out", 32'(signal_out), 32'(e.s));
                chk("busy", 32'(busy), 32'(e.b));
                chk("ovf", 32'(ovf), 32'(e.o));
            end
            for (int c = 0; c < CH; c++) begin
                pc[c] += int'(pulse_out[c]);
                bc[c] += int'(busy[c]);
                oc[c] += int'(ovf[c]);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle(input int ch, input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            async_in[ch] = ~async_in[ch];
            wait_cyc(spacing);
        end
    endtask

    initial begin
        int snap, snapb, lat;
        for (int c = 0; c < CH; c++) begin
            pc[c] = 0; bc[c] = 0; oc[c] = 0;
        end
        rst_n    = 1'b0;
        async_in = '0;
        mode     = '0;
        ovf_clr  = '0;
        wait_cyc(3);
        chk("reset_state", 32'({pulse_out, signal_out, busy, ovf}), 32'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Basic rise on ch0: latency from the sampling edge, busy length.
        snap = pc[0]; snapb = bc[0];
        async_in[0] = 1'b1;
        lat = 99;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (pulse_out[0] && lat == 99) lat = k;
        end
        @(negedge clk);
        async_in[0] = 1'b0;
        wait_cyc(10);
        chk("rise_latency", 32'(lat), 32'(S + 1));
        chk("rise_count", 32'(pc[0] - snap), 32'd1);
        chk("rise_busy_len", 32'(bc[0] - snapb), 32'(1 + GAP));

        // Both-edge burst on ch1.
        mode[3:2] = 2'b10;
        snap = pc[1];
        toggle(1, 6, 2);
        wait_cyc(30);
        chk("both_count", 32'(pc[1] - snap), 32'd6);
        chk("both_no_ovf", 32'(ovf[1]), 32'd0);
        chk("both_idle", 32'(busy[1]), 32'd0);

        // Overflow on ch2, then clear, then clear held during drops.
        mode[5:4] = 2'b10;
        snap = pc[2];
        toggle(2, 24, 2);
        chk("ovf_set", 32'(ovf[2]), 32'd1);
        wait_cyc(40);
        chk("ovf_fewer", 32'(pc[2] - snap < 24), 32'd1);
        chk("ovf_sticky", 32'(ovf[2]), 32'd1);
        ovf_clr[2] = 1'b1;
        wait_cyc(1);
        ovf_clr[2] = 1'b0;
        wait_cyc(1);
        chk("ovf_cleared", 32'(ovf[2]), 32'd0);
        snap = oc[2];
        ovf_clr[2] = 1'b1;
        toggle(2, 24, 2);
        ovf_clr[2] = 1'b0;
        chk("ovf_set_wins", 32'(oc[2] - snap > 0), 32'd1);
        wait_cyc(40);

        // Level mode on ch3, then rises, then fall mode.
        mode[7:6] = 2'b11;
        snap = pc[3];
        toggle(3, 6, 3);
        wait_cyc(5);
        chk("level_no_pulse", 32'(pc[3] - snap), 32'd0);
        mode[7:6] = 2'b00;
        snap = pc[3];
        async_in[3] = 1'b1; wait_cyc(2);
        async_in[3] = 1'b0; wait_cyc(2);
        async_in[3] = 1'b1; wait_cyc(4);
        mode[7:6] = 2'b01;
        wait_cyc(1);
        toggle(3, 6, 3);
        wait_cyc(30);
        chk("mode_drain_falls", 32'(pc[3] - snap), 32'd5);

        // Reset while ch0 holds queued events.
        mode[1:0] = 2'b10;
        toggle(0, 8, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_pulse", 32'(pulse_out), 32'd0);
        chk("midrst_signal", 32'(signal_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        wait_cyc(1);
        rst_n = 1'b1;
        snap = pc[0];
        wait_cyc(15);
        chk("midrst_no_pulse", 32'(pc[0] - snap), 32'd0);

        // Source held high through reset release.
        rst_n = 1'b0;
        mode[1:0] = 2'b00;
        wait_cyc(2);
        async_in[0] = 1'b1;
        wait_cyc(2);
        rst_n = 1'b1;
        snap = pc[0];
        wait_cyc(10);
        chk("pwrup_rise", 32'(pc[0] - snap), 32'd1);
        rst_n = 1'b0;
        mode[1:0] = 2'b01;
        wait_cyc(2);
        rst_n = 1'b1;
        snap = pc[0];
        wait_cyc(10);
        chk("pwrup_fall", 32'(pc[0] - snap), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if (i % 25 == 0) mode = 8'($urandom());
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(2, 0) == 0) async_in[c] = ~async_in[c];
                ovf_clr[c] = ($urandom_range(7, 0) == 0);
            end
            wait_cyc(1);
        end
        async_in = '0;
        ovf_clr  = '0;
        wait_cyc(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
